// File: rtl/iec_sd_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// iec_sd_pkg: shared types for the IEC drive SD-port arbiter.
//   sd_arb_state_t : arbiter FSM state (IDLE, REQ, XFER, DONE)
//   IEC_MAX_DRIVES : upper bound on the number of drive units
//   sd_lba_t       : 32-bit SD block address
// -----------------------------------------------------------------------------
package iec_sd_pkg;

  localparam int IEC_MAX_DRIVES = 4;

  typedef logic [31:0] sd_lba_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } sd_arb_state_t;

endpackage

// File: rtl/iec_sd_arbiter_if.sv
// -----------------------------------------------------------------------------
// iec_sd_arbiter_if: the single host SD block port.
//   sd_lba, sd_blk_cnt : latched address / block count of the granted unit
//   sd_rd, sd_wr       : request levels toward the host
//   sd_ack             : host acknowledge
//   sd_buff_din        : write data toward the host
// Handshake: the master raises sd_rd or sd_wr and holds it, with sd_lba and
// sd_blk_cnt stable, until it sees sd_ack high; it drops the request on the
// following cycle. The host keeps sd_ack high for the whole transfer and the
// transfer is complete on the first cycle sd_ack is low again.
// Modports: master = arbiter side, slave = host side.
// -----------------------------------------------------------------------------
interface iec_sd_arbiter_if;
  import iec_sd_pkg::*;

  sd_lba_t    sd_lba;
  logic [5:0] sd_blk_cnt;
  logic       sd_rd;
  logic       sd_wr;
  logic       sd_ack;
  logic [7:0] sd_buff_din;

  modport master (
    output sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack
  );

  modport slave (
    input  sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
    output sd_ack
  );

endinterface

// File: rtl/iec_sd_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// iec_rr_pick: combinational round-robin priority encoder.
//   pend_i  : pending request vector, one bit per unit
//   last_i  : index of the unit served last
//   valid_o : at least one unit is pending
//   idx_o   : first pending unit searching upward from last_i+1, modulo NDR
// -----------------------------------------------------------------------------
module iec_rr_pick
  import iec_sd_pkg::*;
#(
  parameter int NDR = 2
) (
  input  logic [NDR-1:0] pend_i,
  input  logic [1:0]     last_i,
  output logic           valid_o,
  output logic [1:0]     idx_o
);

  // Widen to the maximum so a 2-bit index always fits the vector exactly.
  logic [IEC_MAX_DRIVES-1:0] pend_w;
  assign pend_w = IEC_MAX_DRIVES'(pend_i);

  always_comb begin
    int j;
    j       = 0;
    valid_o = 1'b0;
    idx_o   = 2'd0;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = NDR; k >= 1; k--) begin
      j = (int'(last_i) + k) % NDR;
      if (pend_w[j[1:0]]) begin
        valid_o = 1'b1;
        idx_o   = j[1:0];
      end
    end
  end

endmodule

// File: rtl/iec_sd_arbiter.sv
// -----------------------------------------------------------------------------
// iec_sd_arbiter: shares one host SD block port between up to four IEC drive
// units, granting one at a time in round-robin order.
//   clk_sys, reset : clock, synchronous active-high reset
//   drv_lba        : per-unit block address (32 x NDR)
//   drv_blk_cnt    : per-unit block count minus one (6 x NDR)
//   drv_rd, drv_wr : per-unit request levels
//   drv_ack        : per-unit acknowledge (sd_ack routed to the granted unit)
//   drv_buff_din   : per-unit write data (8 x NDR)
//   host           : host SD port (iec_sd_arbiter_if.master)
//   busy           : FSM not in IDLE
//   grant          : current or last granted unit
//   dbg_state      : FSM state for observation
//   timeout        : one-cycle watchdog pulse (only with IEC_SD_ARB_TIMEOUT_EN)
// Build option: define IEC_SD_ARB_TIMEOUT_EN to add the REQ/XFER watchdog.
// -----------------------------------------------------------------------------
module iec_sd_arbiter
  import iec_sd_pkg::*;
#(
  parameter int         DRIVES      = 2,
  parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000,
  localparam int        NDR = (DRIVES < 1) ? 1 :
                              (DRIVES > IEC_MAX_DRIVES) ? IEC_MAX_DRIVES : DRIVES
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [32*NDR-1:0]   drv_lba,
  input  logic [6*NDR-1:0]    drv_blk_cnt,
  input  logic [NDR-1:0]      drv_rd,
  input  logic [NDR-1:0]      drv_wr,
  output logic [NDR-1:0]      drv_ack,
  input  logic [8*NDR-1:0]    drv_buff_din,
  iec_sd_arbiter_if.master    host,
  output logic                busy,
  output logic [1:0]          grant,
`ifdef IEC_SD_ARB_TIMEOUT_EN
  output logic                timeout,
`endif
  output sd_arb_state_t       dbg_state
);

  localparam int N = NDR - 1;

  sd_arb_state_t state_q;
  logic [1:0]    grant_q, last_q;
  sd_lba_t       lba_q;
  logic [5:0]    cnt_q;
  logic          rd_q, wr_q;

  logic          pick_valid;
  logic [1:0]    pick_idx;
  sd_lba_t       sel_lba;
  logic [5:0]    sel_cnt;
  logic          sel_wr;
  logic          in_xfer;

  iec_rr_pick #(.NDR(NDR)) u_pick (
    .pend_i  (drv_rd | drv_wr),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Request fields of the unit the picker would grant this cycle.
  always_comb begin
    sel_lba = drv_lba[31:0];
    sel_cnt = drv_blk_cnt[5:0];
    sel_wr  = drv_wr[0];
    for (int i = 0; i < NDR; i++) begin
      if (pick_idx == 2'(i)) begin
        sel_lba = drv_lba[32*i +: 32];
        sel_cnt = drv_blk_cnt[6*i +: 6];
        sel_wr  = drv_wr[i];
      end
    end
  end

  assign in_xfer = (state_q == REQ) || (state_q == XFER);

  // Acknowledge and write-data routing follow the granted unit.
  always_comb begin
    host.sd_buff_din = drv_buff_din[7:0];
    drv_ack          = '0;
    for (int i = 0; i < NDR; i++) begin
      if (grant_q == 2'(i)) begin
        host.sd_buff_din = drv_buff_din[8*i +: 8];
        drv_ack[i]       = host.sd_ack & in_xfer;
      end
    end
  end

`ifdef IEC_SD_ARB_TIMEOUT_EN
  logic [23:0] tmo_cnt_q;
  logic        timeout_q;
  logic        advance;
  logic        tmo_hit;

  // Any normal state transition restarts the watchdog.
  assign advance = ((state_q == IDLE) && !host.sd_ack && pick_valid) ||
                   ((state_q == REQ)  &&  host.sd_ack) ||
                   ((state_q == XFER) && !host.sd_ack) ||
                    (state_q == DONE);
  assign tmo_hit = in_xfer && (tmo_cnt_q == TIMEOUT_CYC - 24'd1);
  assign timeout = timeout_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 2'(N);
      grant_q <= 2'd0;
      lba_q   <= '0;
      cnt_q   <= 6'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
`ifdef IEC_SD_ARB_TIMEOUT_EN
      tmo_cnt_q <= 24'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // A stale acknowledge from an abandoned transfer blocks new grants.
          if (!host.sd_ack && pick_valid) begin
            grant_q <= pick_idx;
            lba_q   <= sel_lba;
            cnt_q   <= sel_cnt;
            wr_q    <= sel_wr;
            rd_q    <= !sel_wr;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (host.sd_ack) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (!host.sd_ack) state_q <= DONE;
        end
        DONE: begin
          last_q  <= grant_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
`ifdef IEC_SD_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
      if (tmo_hit) begin
        rd_q      <= 1'b0;
        wr_q      <= 1'b0;
        state_q   <= DONE;
        timeout_q <= 1'b1;
        tmo_cnt_q <= 24'd0;
      end else if (advance) begin
        tmo_cnt_q <= 24'd0;
      end else if (in_xfer) begin
        tmo_cnt_q <= tmo_cnt_q + 24'd1;
      end
`endif
    end
  end

  assign host.sd_lba     = lba_q;
  assign host.sd_blk_cnt = cnt_q;
  assign host.sd_rd      = rd_q;
  assign host.sd_wr      = wr_q;
  assign busy            = (state_q != IDLE);
  assign grant           = grant_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_iec_sd_arbiter.sv
module tb_iec_sd_arbiter;
  import iec_sd_pkg::*;

  localparam int NDR = 4;

  // ---------------------------------------------------------------- clock/reset
  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  logic [32*NDR-1:0] drv_lba      = '0;
  logic [6*NDR-1:0]  drv_blk_cnt  = '0;
  logic [NDR-1:0]    drv_rd       = '0;
  logic [NDR-1:0]    drv_wr       = '0;
  logic [NDR-1:0]    drv_ack;
  logic [8*NDR-1:0]  drv_buff_din = 32'hDDCC_BBAA;
  logic              busy;
  logic [1:0]        grant;
  sd_arb_state_t     dbg_state;
`ifdef IEC_SD_ARB_TIMEOUT_EN
  logic              timeout;
`endif

  iec_sd_arbiter_if host ();

  iec_sd_arbiter #(.DRIVES(NDR), .TIMEOUT_CYC(24'd100)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .drv_lba      (drv_lba),
    .drv_blk_cnt  (drv_blk_cnt),
    .drv_rd       (drv_rd),
    .drv_wr       (drv_wr),
    .drv_ack      (drv_ack),
    .drv_buff_din (drv_buff_din),
    .host         (host.master),
    .busy         (busy),
    .grant        (grant),
`ifdef IEC_SD_ARB_TIMEOUT_EN
    .timeout      (timeout),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int         checks   = 0;
  int         failures = 0;
  logic [1:0] exp_q[$];
  sd_lba_t    lba_m[NDR];

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_lba();
    for (int i = 0; i < NDR; i++) drv_lba[32*i +: 32] = lba_m[i];
  endtask

  // Host side of one transfer, starting in REQ; ends with the FSM in IDLE.
  task automatic host_xfer(input logic [1:0] g, input int delay, input int len);
    repeat (delay) tick();
    host.sd_ack = 1'b1;
    #1;
    check_eq("drv_ack_route", drv_ack, 4'b0001 << g);
    repeat (len) tick();
    host.sd_ack = 1'b0;
    tick();
    tick();
    check_eq("idle_after_xfer", busy, 1'b0);
  endtask

  // Bounded wait for a host request; returns cycles taken.
  task automatic wait_grant(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(host.sd_rd || host.sd_wr) && n < 8);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int n;
    logic [1:0] g;
    host.sd_ack = 1'b0;
    do_reset();

    // Reset state
    check_eq("rst_busy",  busy, 1'b0);
    check_eq("rst_grant", grant, 2'd0);
    check_eq("rst_rd",    host.sd_rd, 1'b0);
    check_eq("rst_wr",    host.sd_wr, 1'b0);
    check_eq("rst_ack",   drv_ack, 4'b0000);
    check_eq("rst_lba",   host.sd_lba, 32'h0);
    check_eq("rst_cnt",   host.sd_blk_cnt, 6'd0);
    check_eq("rst_state", dbg_state, IDLE);
    check_eq("rst_bdin",  host.sd_buff_din, 8'hAA);

    // Single read from unit 1
    drv_lba[63:32]    = 32'h0000_1234;
    drv_blk_cnt[11:6] = 6'd7;
    drv_rd            = 4'b0010;
    tick();
    check_eq("rd_req",   host.sd_rd, 1'b1);
    check_eq("rd_grant", grant, 2'd1);
    check_eq("rd_lba",   host.sd_lba, 32'h0000_1234);
    check_eq("rd_cnt",   host.sd_blk_cnt, 6'd7);
    check_eq("rd_busy",  busy, 1'b1);
    drv_rd = 4'b0000;   // dropping the request must not cancel
    repeat (4) tick();
    check_eq("rd_hold",  host.sd_rd, 1'b1);
    host.sd_ack = 1'b1;
    #1;
    check_eq("rd_ack0",  drv_ack, 4'b0010);
    tick();
    check_eq("rd_drop",  host.sd_rd, 1'b0);
    check_eq("rd_xfer",  dbg_state, XFER);
    repeat (19) tick();
    check_eq("rd_ack_x", drv_ack, 4'b0010);
    host.sd_ack = 1'b0;
    #1;
    check_eq("rd_ackoff", drv_ack, 4'b0000);
    tick();
    check_eq("rd_done",  busy, 1'b1);
    tick();
    check_eq("rd_idle",  busy, 1'b0);

    // Write wins over read on the same unit
    drv_rd = 4'b0001;
    drv_wr = 4'b0001;
    tick();
    check_eq("wr_wr",    host.sd_wr, 1'b1);
    check_eq("wr_rd",    host.sd_rd, 1'b0);
    check_eq("wr_grant", grant, 2'd0);
    drv_rd = '0;
    drv_wr = '0;
    host.sd_ack = 1'b1;
    tick();
    drv_buff_din = 32'hDDCC_BB5A;
    #1;
    check_eq("wr_bdin0", host.sd_buff_din, 8'h5A);
    drv_buff_din = 32'h1122_33C3;
    #1;
    check_eq("wr_bdin1", host.sd_buff_din, 8'hC3);
    host.sd_ack = 1'b0;
    tick();
    tick();

    // Reset during XFER, then stale ack, then unit 0 beats unit 1
    drv_rd = 4'b0100;
    tick();
    check_eq("mr_grant", grant, 2'd2);
    drv_rd = '0;
    host.sd_ack = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check_eq("mr_busy",  busy, 1'b0);
    check_eq("mr_rd",    host.sd_rd, 1'b0);
    check_eq("mr_wr",    host.sd_wr, 1'b0);
    check_eq("mr_ack",   drv_ack, 4'b0000);
    check_eq("mr_grant0", grant, 2'd0);
    reset  = 1'b0;
    drv_rd = 4'b0011;
    tick();
    check_eq("stale_ack", busy, 1'b0);
    host.sd_ack = 1'b0;
    tick();
    check_eq("post_rst_g", grant, 2'd0);
    check_eq("post_rst_b", busy, 1'b1);
    host_xfer(2'd0, 1, 3);
    tick();
    check_eq("next_g1",  grant, 2'd1);
    host_xfer(2'd1, 0, 2);
    drv_rd = '0;

    // Round-robin fairness, all units requesting continuously
    lba_m[0] = 32'hA000_0000;
    lba_m[1] = 32'hA100_0011;
    lba_m[2] = 32'hA200_0022;
    lba_m[3] = 32'hA300_0033;
    load_lba();
    drv_rd = 4'b1111;
    exp_q  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    while (exp_q.size() > 0) begin
      g = exp_q.pop_front();
      wait_grant(n);
      check_eq("rr_spacing", n, 1);
      check_eq("rr_grant",   grant, g);
      check_eq("rr_lba",     host.sd_lba, lba_m[g]);
      host_xfer(g, 1, 2);
    end
    drv_rd = '0;

`ifdef IEC_SD_ARB_TIMEOUT_EN
    // Watchdog: host never acknowledges
    do_reset();
    drv_rd = 4'b0011;
    tick();
    check_eq("to_req",   host.sd_rd, 1'b1);
    drv_rd = 4'b0010;
    repeat (99) tick();
    check_eq("to_early", timeout, 1'b0);
    tick();
    check_eq("to_pulse", timeout, 1'b1);
    check_eq("to_drop",  host.sd_rd, 1'b0);
    tick();
    check_eq("to_once",  timeout, 1'b0);
    tick();
    check_eq("to_next",  grant, 2'd1);
    check_eq("to_nrd",   host.sd_rd, 1'b1);
    drv_rd = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
